// File: rtl/arp_responder.sv
// ARP responder: answers ARP requests for this station's IPv4 address with a 28-byte reply stream.
// Optional request/reply counters are built when ARP_CNT_EN is defined.
module arp_responder #(
    parameter logic [47:0] P_MAC_ADDR = 48'h00183E02523A,
    parameter logic [31:0] P_IP_ADDR  = 32'hC0A8010A
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        rx_byte_vld,
    output logic        rx_byte_rdy,
    input  logic [7:0]  rx_byte,
    input  logic        rx_byte_last,
    input  logic [15:0] rx_pkt_type,
    output logic        tx_byte_vld,
    input  logic        tx_byte_rdy,
    output logic [7:0]  tx_byte,
    output logic        tx_byte_last,
    output logic [47:0] tx_dst_mac,
    output logic [15:0] tx_pkt_type
`ifdef ARP_CNT_EN
    ,
    output logic [15:0] req_cnt,
    output logic [15:0] reply_cnt
`endif
);

    localparam logic [15:0] ARP_TYPE = 16'h0806;
    localparam logic [63:0] HDR      = 64'h0001_0800_0604_0001;
    localparam logic [4:0]  LAST_IDX = 5'd27;

    typedef enum logic [1:0] {IDLE, PARSE, DROP, REPLY} state_t;

    state_t      state;
    logic [4:0]  idx;
    logic [47:0] sha;
    logic [31:0] spa;
    logic        pad_match;

    logic        rx_xfer;
    logic        tx_xfer;
    logic        chk_en;
    logic [7:0]  chk_byte;
    logic        byte_ok;
    logic        parse_done;
    logic [4:0]  nxt_idx;
    logic [4:0]  rep_sel;
    logic [223:0] reply_vec;
    logic [7:0]  reply_byte_nxt;

    assign tx_pkt_type = ARP_TYPE;
    assign rx_xfer     = rx_byte_vld && rx_byte_rdy;
    assign tx_xfer     = tx_byte_vld && tx_byte_rdy;
    assign nxt_idx     = idx + 5'd1;

    // Expected value for the checked fields: fixed header (0-7) and target IP (24-27)
    always_comb begin
        chk_en   = 1'b0;
        chk_byte = 8'h00;
        if (idx < 5'd8) begin
            chk_en   = 1'b1;
            chk_byte = HDR[{~idx[2:0], 3'b000} +: 8];
        end else if (idx >= 5'd24) begin
            chk_en   = 1'b1;
            chk_byte = P_IP_ADDR[{~idx[1:0], 3'b000} +: 8];
        end
    end

    assign byte_ok    = !chk_en || (rx_byte == chk_byte);
    assign parse_done = rx_xfer && rx_byte_last && (pad_match || (idx == LAST_IDX && byte_ok));

    // Reply image: header with OPER=2, our addresses, then the requester's addresses
    assign reply_vec      = {HDR[63:16], 16'h0002, P_MAC_ADDR, P_IP_ADDR, sha, spa};
    assign rep_sel        = LAST_IDX - nxt_idx;
    assign reply_byte_nxt = reply_vec[{rep_sel, 3'b000} +: 8];

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            sha          <= '0;
            spa          <= '0;
            pad_match    <= 1'b0;
            rx_byte_rdy  <= 1'b1;
            tx_byte_vld  <= 1'b0;
            tx_byte      <= '0;
            tx_byte_last <= 1'b0;
            tx_dst_mac   <= '0;
`ifdef ARP_CNT_EN
            req_cnt      <= '0;
            reply_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (rx_xfer) begin
                        pad_match <= 1'b0;
                        if (rx_pkt_type != ARP_TYPE || !byte_ok) begin
                            state <= rx_byte_last ? IDLE : DROP;
                        end else if (!rx_byte_last) begin
                            state <= PARSE;
                            idx   <= 5'd1;
                        end
                    end
                end

                PARSE: begin
                    if (parse_done) begin
                        state        <= REPLY;
                        idx          <= '0;
                        pad_match    <= 1'b0;
                        rx_byte_rdy  <= 1'b0;
                        tx_byte_vld  <= 1'b1;
                        tx_byte      <= HDR[63:56];
                        tx_byte_last <= 1'b0;
                        tx_dst_mac   <= sha;
`ifdef ARP_CNT_EN
                        req_cnt      <= req_cnt + 16'd1;
`endif
                    end else if (rx_xfer && !pad_match) begin
                        if (!byte_ok) begin
                            state <= rx_byte_last ? IDLE : DROP;
                            idx   <= '0;
                        end else if (idx == LAST_IDX) begin
                            pad_match <= 1'b1;
                        end else if (rx_byte_last) begin
                            state <= IDLE;
                            idx   <= '0;
                        end else begin
                            idx <= nxt_idx;
                        end
                        if (idx >= 5'd8 && idx <= 5'd13) begin
                            sha <= {sha[39:0], rx_byte};
                        end
                        if (idx >= 5'd14 && idx <= 5'd17) begin
                            spa <= {spa[23:0], rx_byte};
                        end
                    end
                end

                DROP: begin
                    if (rx_xfer && rx_byte_last) begin
                        state <= IDLE;
                    end
                end

                REPLY: begin
                    if (tx_xfer) begin
                        if (idx == LAST_IDX) begin
                            state        <= IDLE;
                            idx          <= '0;
                            rx_byte_rdy  <= 1'b1;
                            tx_byte_vld  <= 1'b0;
                            tx_byte      <= '0;
                            tx_byte_last <= 1'b0;
`ifdef ARP_CNT_EN
                            reply_cnt    <= reply_cnt + 16'd1;
`endif
                        end else begin
                            idx          <= nxt_idx;
                            tx_byte      <= reply_byte_nxt;
                            tx_byte_last <= (nxt_idx == LAST_IDX);
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arp_responder.sv
// Scoreboard bench for arp_responder: a frame-level reference model predicts replies,
// a monitor pops and compares every tx transfer.
module tb_arp_responder;

    localparam logic [47:0] MAC = 48'h00183E02523A;
    localparam logic [31:0] IP  = 32'hC0A8010A;

    logic        sys_clk;
    logic        rst;
    logic        rx_byte_vld;
    logic        rx_byte_rdy;
    logic [7:0]  rx_byte;
    logic        rx_byte_last;
    logic [15:0] rx_pkt_type;
    logic        tx_byte_vld;
    logic        tx_byte_rdy;
    logic [7:0]  tx_byte;
    logic        tx_byte_last;
    logic [47:0] tx_dst_mac;
    logic [15:0] tx_pkt_type;
`ifdef ARP_CNT_EN
    logic [15:0] req_cnt;
    logic [15:0] reply_cnt;
`endif

    arp_responder dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .rx_byte_vld  (rx_byte_vld),
        .rx_byte_rdy  (rx_byte_rdy),
        .rx_byte      (rx_byte),
        .rx_byte_last (rx_byte_last),
        .rx_pkt_type  (rx_pkt_type),
        .tx_byte_vld  (tx_byte_vld),
        .tx_byte_rdy  (tx_byte_rdy),
        .tx_byte      (tx_byte),
        .tx_byte_last (tx_byte_last),
        .tx_dst_mac   (tx_dst_mac),
        .tx_pkt_type  (tx_pkt_type)
`ifdef ARP_CNT_EN
        ,
        .req_cnt      (req_cnt),
        .reply_cnt    (reply_cnt)
`endif
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [7:0]  b;
        logic        last;
        logic [47:0] mac;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  frame[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          rep_pos = 0;
    int          vld_cycles = 0;
    int          rdy_mode = 0;
    int          pat_ph = 0;
    int          m_req = 0;
    int          m_reply = 0;
    bit          use_gaps = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Reference model: a reply is due iff the frame is ARP, long enough, has the
    // request header, and targets our IP.
    function automatic bit model_match(input logic [15:0] ptype);
        logic [7:0] hdr [8] = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01};
        if (ptype != 16'h0806 || frame.size() < 28) return 1'b0;
        for (int k = 0; k < 8; k++)
            if (frame[k] != hdr[k]) return 1'b0;
        for (int k = 0; k < 4; k++)
            if (frame[24+k] != 8'(IP >> (8 * (3 - k)))) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_reply();
        logic [7:0]  r[$];
        logic [47:0] mac;
        r = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h02};
        for (int k = 0; k < 6; k++) r.push_back(8'(MAC >> (8 * (5 - k))));
        for (int k = 0; k < 4; k++) r.push_back(8'(IP >> (8 * (3 - k))));
        for (int k = 8; k < 18; k++) r.push_back(frame[k]);
        mac = {frame[8], frame[9], frame[10], frame[11], frame[12], frame[13]};
        for (int k = 0; k < 28; k++) exp_q.push_back('{b: r[k], last: (k == 27), mac: mac});
        m_req++;
    endtask

    task automatic make_req(input logic [47:0] sha, input logic [31:0] spa,
                            input logic [31:0] tpa, input int len);
        frame = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01};
        for (int k = 0; k < 6; k++) frame.push_back(8'(sha >> (8 * (5 - k))));
        for (int k = 0; k < 4; k++) frame.push_back(8'(spa >> (8 * (3 - k))));
        for (int k = 0; k < 6; k++) frame.push_back(8'($urandom));
        for (int k = 0; k < 4; k++) frame.push_back(8'(tpa >> (8 * (3 - k))));
        while (frame.size() < len) frame.push_back(8'($urandom));
        while (frame.size() > len) void'(frame.pop_back());
    endtask

    task automatic make_random(input int len);
        frame.delete();
        for (int k = 0; k < len; k++) frame.push_back(8'($urandom));
    endtask

    // Drives one frame, then checks the reply (or its absence) starts the next cycle
    task automatic send_frame(input logic [15:0] ptype);
        bit exp_reply;
        bit xfer;
        int i = 0;
        int guard = 0;
        exp_reply = model_match(ptype);
        if (exp_reply) push_reply();
        vld_cycles = 0;
        rx_pkt_type = ptype;
        while (i < frame.size()) begin
            rx_byte      = frame[i];
            rx_byte_last = (i == frame.size() - 1);
            rx_byte_vld  = use_gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge sys_clk);
            check("rx_rdy_in_frame", rx_byte_rdy, 1);
            xfer = rx_byte_vld && rx_byte_rdy;
            @(posedge sys_clk);
            #1;
            if (xfer) i++;
            guard++;
            if (guard > 2000) begin
                timeout_fail("rx_frame");
                break;
            end
        end
        rx_byte_vld  = 1'b0;
        rx_byte_last = 1'b0;
        @(negedge sys_clk);
        check("latency_tx_vld", tx_byte_vld, exp_reply);
        check("latency_rx_rdy", rx_byte_rdy, !exp_reply);
    endtask

    task automatic wait_drain();
        int cycles = 0;
        while (exp_q.size() > 0 && cycles < 1000) begin
            @(posedge sys_clk);
            cycles++;
        end
        if (exp_q.size() > 0) begin
            timeout_fail("reply_drain");
            exp_q.delete();
        end
        @(negedge sys_clk);
        check("post_reply_tx_vld", tx_byte_vld, 0);
        check("post_reply_rx_rdy", rx_byte_rdy, 1);
        if (rdy_mode == 0 && m_req > 0 && rep_pos == 0 && vld_cycles != 0)
            check("reply_cycles", vld_cycles, 28);
        @(posedge sys_clk);
        #1;
    endtask

    always @(posedge sys_clk) begin
        #1;
        case (rdy_mode)
            0: tx_byte_rdy = 1'b1;
            1: begin
                tx_byte_rdy = (pat_ph == 0 || pat_ph == 3);
                pat_ph = (pat_ph + 1) % 4;
            end
            default: tx_byte_rdy = ($urandom_range(0, 2) != 0);
        endcase
    end

    // Monitor: compares each tx transfer with the scoreboard and checks stall stability
    logic        stall_prev = 1'b0;
    logic [8:0]  held;
    exp_t        e;
    always @(negedge sys_clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (tx_byte_vld) vld_cycles++;
            if (stall_prev) begin
                check("stall_vld", tx_byte_vld, 1);
                check("stall_hold", {tx_byte, tx_byte_last}, held);
            end
            if (tx_byte_vld && tx_byte_rdy) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_tx: got byte %0h expected no transfer", tx_byte);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", tx_byte, e.b);
                    check("tx_last", tx_byte_last, e.last);
                    check("tx_dst_mac", tx_dst_mac, e.mac);
                    check("rx_rdy_in_reply", rx_byte_rdy, 0);
                    check("tx_pkt_type", tx_pkt_type, 16'h0806);
                    rep_pos++;
                    if (e.last) begin
                        rep_pos = 0;
                        m_reply++;
                    end
                end
            end
            stall_prev = tx_byte_vld && !tx_byte_rdy;
            held = {tx_byte, tx_byte_last};
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        int guard;
        logic [31:0] tpa;
        rst = 1'b1;
        rx_byte_vld = 1'b0;
        rx_byte = 8'h00;
        rx_byte_last = 1'b0;
        rx_pkt_type = 16'h0000;
        tx_byte_rdy = 1'b1;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("reset_rx_rdy", rx_byte_rdy, 1);
        check("reset_tx_vld", tx_byte_vld, 0);
        check("reset_tx_byte", tx_byte, 0);
        check("reset_tx_last", tx_byte_last, 0);
        check("reset_dst_mac", tx_dst_mac, 0);
`ifdef ARP_CNT_EN
        check("reset_req_cnt", req_cnt, 0);
        check("reset_reply_cnt", reply_cnt, 0);
`endif
        @(posedge sys_clk);
        #1;
        rst = 1'b0;

        // Basic request with full-rate transmit
        make_req(48'h021122334455, 32'hC0A80101, IP, 28);
        send_frame(16'h0806);
        wait_drain();
`ifdef ARP_CNT_EN
        check("cnt_req_first", req_cnt, 1);
        check("cnt_reply_first", reply_cnt, 1);
`endif

        // Wrong target IP, then an IPv4 frame
        make_req(48'h021122334455, 32'hC0A80101, 32'hC0A8010B, 28);
        send_frame(16'h0806);
        wait_drain();
        make_random(46);
        send_frame(16'h0800);
        wait_drain();

        // Padded request: reply follows the final padding byte
        make_req(48'h0A0B0C0D0E0F, 32'hC0A80164, IP, 46);
        send_frame(16'h0806);
        wait_drain();

        // Back-pressured reply
        rdy_mode = 1;
        pat_ph = 0;
        make_req(48'h02AABBCCDDEE, 32'hC0A80102, IP, 28);
        send_frame(16'h0806);
        wait_drain();
        rdy_mode = 0;

        // Short frame then a normal request
        make_req(48'h021122334455, 32'hC0A80101, IP, 21);
        send_frame(16'h0806);
        wait_drain();
        make_req(48'h021122334466, 32'hC0A80103, IP, 28);
        send_frame(16'h0806);
        wait_drain();

        // Reset while byte 10 of the reply is on the bus
        make_req(48'h02DEADBEEF01, 32'hC0A80104, IP, 28);
        send_frame(16'h0806);
        guard = 0;
        while (rep_pos < 10 && guard < 200) begin
            @(posedge sys_clk);
            #1;
            guard++;
        end
        if (rep_pos < 10) timeout_fail("reply_to_byte10");
        rst = 1'b1;
        @(posedge sys_clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        rep_pos = 0;
        m_req = 0;
        m_reply = 0;
        @(negedge sys_clk);
        check("rst_mid_tx_vld", tx_byte_vld, 0);
        check("rst_mid_rx_rdy", rx_byte_rdy, 1);
`ifdef ARP_CNT_EN
        check("rst_mid_req_cnt", req_cnt, 0);
        check("rst_mid_reply_cnt", reply_cnt, 0);
`endif
        @(posedge sys_clk);
        #1;
        make_req(48'h02DEADBEEF02, 32'hC0A80105, IP, 28);
        send_frame(16'h0806);
        wait_drain();

        // Randomised mix of frames, gaps and transmit back-pressure
        use_gaps = 1'b1;
        for (int n = 0; n < 30; n++) begin
            rdy_mode = $urandom_range(0, 2);
            kind = $urandom_range(0, 5);
            tpa = IP;
            if (kind == 1) tpa = IP ^ (32'h1 << $urandom_range(0, 31));
            make_req({$urandom, $urandom}, $urandom, tpa, (kind == 3) ? $urandom_range(1, 27)
                                                                       : $urandom_range(28, 60));
            if (kind == 2) frame[$urandom_range(0, 7)] ^= 8'(1 << $urandom_range(0, 7));
            if (kind == 4) make_random($urandom_range(1, 60));
            send_frame((kind == 5) ? 16'h0800 : 16'h0806);
            wait_drain();
        end
        rdy_mode = 0;

`ifdef ARP_CNT_EN
        check("final_req_cnt", req_cnt, 16'(m_req));
        check("final_reply_cnt", reply_cnt, 16'(m_reply));
`endif
        check("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
